regfile_mp: RTL and testbench

Parametrised multi-ported register file, successor to the single-write 32x32 regfile in the datapath.
- Two write ports with defined collision priority.
- Two asynchronous read ports with optional same-cycle write-to-read bypass.
- Optional hardwired-zero register 0.
- Per-entry pending (scoreboard) bits for hazard detection.
- Sequential init sweep after reset or soft clear.
Sits between the decode/issue stage (read, reserve) and the adder/writeback stage (write).

---
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports (port 1 wins collisions), two
// asynchronous read ports with optional write bypass, pending bits, init sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_CLR,
    input  logic              i_WE0,
    input  logic [ADDR_W-1:0] i_S0,
    input  logic [DATA_W-1:0] i_D0,
    input  logic              i_WE1,
    input  logic [ADDR_W-1:0] i_S1,
    input  logic [DATA_W-1:0] i_D1,
    input  logic [ADDR_W-1:0] i_R0,
    input  logic [ADDR_W-1:0] i_R1,
    input  logic              i_RSV,
    input  logic [ADDR_W-1:0] i_RSV_A,
    output logic [DATA_W-1:0] o_Q0,
    output logic [DATA_W-1:0] o_Q1,
    output logic              o_BUSY0,
    output logic              o_BUSY1,
    output logic              o_READY
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;

    logic run, clear, accept, we0_ok, we1_ok, rsv_ok;

    // A clear request blocks every write/reserve in its own cycle; the sweep wipes state anyway.
    assign run    = (state_q == ST_RUN);
    assign clear  = i_RST || (run && i_CLR);
    assign accept = run && !clear;
    assign we0_ok = accept && i_WE0 && !(ZERO_REG && (i_S0 == '0));
    assign we1_ok = accept && i_WE1 && !(ZERO_REG && (i_S1 == '0));
    assign rsv_ok = accept && i_RSV && !(ZERO_REG && (i_RSV_A == '0));
    assign o_READY = run;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_CLR) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the array has no reset branch; the INIT sweep zeroes one entry per cycle instead.
    always_ff @(posedge i_CLK) begin
        if (!run) mem_q[cnt_q[ADDR_W-1:0]] <= '0;
        if (we0_ok) mem_q[i_S0] <= i_D0;
        if (we1_ok) mem_q[i_S1] <= i_D1;
    end

    // Reservation is applied after the write clears so a same-address reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (we0_ok) pend_d[i_S0] = 1'b0;
        if (we1_ok) pend_d[i_S1] = 1'b0;
        if (rsv_ok) pend_d[i_RSV_A] = 1'b1;
    end

    always_ff @(posedge i_CLK) begin
        if (clear) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = mem_q[a];
        if (BYPASS && we0_ok && (i_S0 == a)) d = i_D0;
        if (BYPASS && we1_ok && (i_S1 == a)) d = i_D1;
        if (!run || (ZERO_REG && (a == '0))) d = '0;
        return d;
    endfunction

    function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = pend_q[a];
        if (BYPASS && ((we0_ok && (i_S0 == a)) || (we1_ok && (i_S1 == a)))) b = 1'b0;
        if (!run || (ZERO_REG && (a == '0))) b = 1'b0;
        return b;
    endfunction

    always_comb begin
        o_Q0    = rd_data(i_R0);
        o_Q1    = rd_data(i_R1);
        o_BUSY0 = rd_busy(i_R0);
        o_BUSY1 = rd_busy(i_R1);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus;
// expectations come from a small model and pass through a scoreboard queue.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clr, we0, we1, rsv;
    logic [ADDR_W-1:0] s0, s1, r0, r1, rsv_a;
    logic [DATA_W-1:0] d0, d1;
    logic [DATA_W-1:0] q0_a, q1_a, q0_b, q1_b;
    logic              busy0_a, busy1_a, busy0_b, busy1_b, ready_a, ready_b;

    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                model_pend [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_v;
    int                n_tests = 0;
    int                n_fail  = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_CLR(clr),
        .i_WE0(we0), .i_S0(s0), .i_D0(d0), .i_WE1(we1), .i_S1(s1), .i_D1(d1),
        .i_R0(r0), .i_R1(r1), .i_RSV(rsv), .i_RSV_A(rsv_a),
        .o_Q0(q0_a), .o_Q1(q1_a), .o_BUSY0(busy0_a), .o_BUSY1(busy1_a), .o_READY(ready_a)
    );

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_CLR(clr),
        .i_WE0(we0), .i_S0(s0), .i_D0(d0), .i_WE1(we1), .i_S1(s1), .i_D1(d1),
        .i_R0(r0), .i_R1(r1), .i_RSV(rsv), .i_RSV_A(rsv_a),
        .o_Q0(q0_b), .o_Q1(q1_b), .o_BUSY0(busy0_b), .o_BUSY1(busy1_b), .o_READY(ready_b)
    );

    task automatic idle();
        clr = 1'b0; we0 = 1'b0; we1 = 1'b0; rsv = 1'b0;
        s0 = '0; s1 = '0; d0 = '0; d1 = '0; r0 = '0; r1 = '0; rsv_a = '0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled #1 later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            model_pend[i] = 1'b0;
        end
    endtask

    // Walks one full sweep: ready low for DEPTH cycles, high on the next.
    task automatic sweep_checks(input string tag);
        for (int c = 1; c <= DEPTH + 1; c++) begin
            exp_q.push_back(DATA_W'(c == DEPTH + 1));
            exp_q.push_back(DATA_W'(c == DEPTH + 1));
            if (c <= DEPTH) begin
                exp_q.push_back('0);
                exp_q.push_back('0);
            end
            #1;
            exp_v = exp_q.pop_front(); n_tests++;
            if (DATA_W'(ready_a) !== exp_v) begin n_fail++; $display("FAIL %s_ready_a cycle %0d: got %0h want %0h", tag, c, ready_a, exp_v); end
            exp_v = exp_q.pop_front(); n_tests++;
            if (DATA_W'(ready_b) !== exp_v) begin n_fail++; $display("FAIL %s_ready_b cycle %0d: got %0h want %0h", tag, c, ready_b, exp_v); end
            if (c <= DEPTH) begin
                exp_v = exp_q.pop_front(); n_tests++;
                if (q0_a !== exp_v) begin n_fail++; $display("FAIL %s_init_q0 cycle %0d: got %0h want %0h", tag, c, q0_a, exp_v); end
                exp_v = exp_q.pop_front(); n_tests++;
                if (DATA_W'(busy1_a) !== exp_v) begin n_fail++; $display("FAIL %s_init_busy1 cycle %0d: got %0h want %0h", tag, c, busy1_a, exp_v); end
                tick();
            end
        end
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            r0 = ADDR_W'(i);
            r1 = ADDR_W'(DEPTH - 1 - i);
            exp_q.push_back(model_mem[i]);
            exp_q.push_back(model_mem[DEPTH - 1 - i]);
            exp_q.push_back(DATA_W'(model_pend[i]));
            exp_q.push_back(model_mem[i]);
            #1;
            exp_v = exp_q.pop_front(); n_tests++;
            if (q0_a !== exp_v) begin n_fail++; $display("FAIL %s_q0_a entry %0d: got %0h want %0h", tag, i, q0_a, exp_v); end
            exp_v = exp_q.pop_front(); n_tests++;
            if (q1_a !== exp_v) begin n_fail++; $display("FAIL %s_q1_a entry %0d: got %0h want %0h", tag, DEPTH - 1 - i, q1_a, exp_v); end
            exp_v = exp_q.pop_front(); n_tests++;
            if (DATA_W'(busy0_a) !== exp_v) begin n_fail++; $display("FAIL %s_busy0_a entry %0d: got %0h want %0h", tag, i, busy0_a, exp_v); end
            exp_v = exp_q.pop_front(); n_tests++;
            if (q0_b !== exp_v) begin n_fail++; $display("FAIL %s_q0_b entry %0d: got %0h want %0h", tag, i, q0_b, exp_v); end
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // Writes and a reservation held active throughout INIT must all be dropped.
        we0 = 1'b1; s0 = 5'd1; d0 = 32'hFFFF_FFFF;
        we1 = 1'b1; s1 = 5'd2; d1 = 32'h1234_5678;
        rsv = 1'b1; rsv_a = 5'd3;
        r0 = 5'd1; r1 = 5'd3;
        sweep_checks("reset");
        idle();
        model_clear();
        readback_all("reset_rd");
    endtask

    task automatic test_basic();
        we0 = 1'b1; s0 = 5'd5; d0 = 32'hDEAD_BEEF;
        tick();
        idle();
        model_mem[5] = 32'hDEAD_BEEF;
        r0 = 5'd5;
        we1 = 1'b1; s1 = 5'd0; d1 = 32'h0000_1234; r1 = 5'd0;
        exp_q.push_back(model_mem[5]);
        exp_q.push_back(model_mem[5]);
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (q0_a !== exp_v) begin n_fail++; $display("FAIL basic_q0_a: got %0h want %0h", q0_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q0_b !== exp_v) begin n_fail++; $display("FAIL basic_q0_b: got %0h want %0h", q0_b, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q1_a !== exp_v) begin n_fail++; $display("FAIL zero_bypass_q1_a: got %0h want %0h", q1_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q1_b !== exp_v) begin n_fail++; $display("FAIL zero_bypass_q1_b: got %0h want %0h", q1_b, exp_v); end
        tick();
        idle();
        r1 = 5'd0;
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (q1_a !== exp_v) begin n_fail++; $display("FAIL zero_reg_q1: got %0h want %0h", q1_a, exp_v); end
        we1 = 1'b1; s1 = 5'd6; d1 = 32'hCAFE_F00D;
        tick();
        idle();
        model_mem[6] = 32'hCAFE_F00D;
        r1 = 5'd6;
        exp_q.push_back(model_mem[6]);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (q1_a !== exp_v) begin n_fail++; $display("FAIL port1_write_q1: got %0h want %0h", q1_a, exp_v); end
    endtask

    task automatic test_collision();
        idle();
        r0 = 5'd7;
        we0 = 1'b1; s0 = 5'd7; d0 = 32'h0000_AAAA;
        we1 = 1'b1; s1 = 5'd7; d1 = 32'h0000_5555;
        exp_q.push_back(32'h0000_5555);
        exp_q.push_back(model_mem[7]);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (q0_a !== exp_v) begin n_fail++; $display("FAIL collide_bypass_a: got %0h want %0h", q0_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q0_b !== exp_v) begin n_fail++; $display("FAIL collide_nobypass_b: got %0h want %0h", q0_b, exp_v); end
        tick();
        idle();
        model_mem[7] = 32'h0000_5555;
        r0 = 5'd7;
        // Port 0 alone: bypass on read port 1 from write port 0.
        we0 = 1'b1; s0 = 5'd8; d0 = 32'h0000_BEEF; r1 = 5'd8;
        exp_q.push_back(model_mem[7]);
        exp_q.push_back(model_mem[7]);
        exp_q.push_back(32'h0000_BEEF);
        exp_q.push_back(model_mem[8]);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (q0_a !== exp_v) begin n_fail++; $display("FAIL collide_stored_a: got %0h want %0h", q0_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q0_b !== exp_v) begin n_fail++; $display("FAIL collide_stored_b: got %0h want %0h", q0_b, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q1_a !== exp_v) begin n_fail++; $display("FAIL port0_bypass_a: got %0h want %0h", q1_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q1_b !== exp_v) begin n_fail++; $display("FAIL port0_nobypass_b: got %0h want %0h", q1_b, exp_v); end
        tick();
        idle();
        model_mem[8] = 32'h0000_BEEF;
    endtask

    task automatic test_scoreboard();
        idle();
        rsv = 1'b1; rsv_a = 5'd3;
        tick();
        idle();
        model_pend[3] = 1'b1;
        r0 = 5'd3;
        exp_q.push_back(DATA_W'(model_pend[3]));
        exp_q.push_back(DATA_W'(model_pend[3]));
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_a) !== exp_v) begin n_fail++; $display("FAIL reserve_busy_a: got %0h want %0h", busy0_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_b) !== exp_v) begin n_fail++; $display("FAIL reserve_busy_b: got %0h want %0h", busy0_b, exp_v); end
        we0 = 1'b1; s0 = 5'd3; d0 = 32'h0000_0077;
        exp_q.push_back('0);
        exp_q.push_back(DATA_W'(model_pend[3]));
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_a) !== exp_v) begin n_fail++; $display("FAIL write_busy_bypass_a: got %0h want %0h", busy0_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_b) !== exp_v) begin n_fail++; $display("FAIL write_busy_nobypass_b: got %0h want %0h", busy0_b, exp_v); end
        tick();
        idle();
        model_pend[3] = 1'b0;
        model_mem[3]  = 32'h0000_0077;
        r0 = 5'd3;
        exp_q.push_back(DATA_W'(model_pend[3]));
        exp_q.push_back(DATA_W'(model_pend[3]));
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_a) !== exp_v) begin n_fail++; $display("FAIL released_busy_a: got %0h want %0h", busy0_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_b) !== exp_v) begin n_fail++; $display("FAIL released_busy_b: got %0h want %0h", busy0_b, exp_v); end
        rsv = 1'b1; rsv_a = 5'd9;
        we1 = 1'b1; s1 = 5'd9; d1 = 32'h0000_0099;
        tick();
        idle();
        model_pend[9] = 1'b1;
        model_mem[9]  = 32'h0000_0099;
        r1 = 5'd9;
        exp_q.push_back(DATA_W'(model_pend[9]));
        exp_q.push_back(model_mem[9]);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy1_a) !== exp_v) begin n_fail++; $display("FAIL set_wins_busy1: got %0h want %0h", busy1_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q1_a !== exp_v) begin n_fail++; $display("FAIL set_wins_q1: got %0h want %0h", q1_a, exp_v); end
        rsv = 1'b1; rsv_a = 5'd0;
        tick();
        idle();
        r0 = 5'd0;
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_a) !== exp_v) begin n_fail++; $display("FAIL zero_reserve_busy0: got %0h want %0h", busy0_a, exp_v); end
    endtask

    task automatic test_clear();
        idle();
        for (int i = 1; i <= 4; i++) begin
            we0 = 1'b1; s0 = ADDR_W'(i); d0 = 32'h0000_0100 + DATA_W'(i);
            tick();
            model_mem[i] = 32'h0000_0100 + DATA_W'(i);
        end
        idle();
        rsv = 1'b1; rsv_a = 5'd2;
        tick();
        idle();
        model_pend[2] = 1'b1;
        r0 = 5'd2;
        exp_q.push_back(DATA_W'(model_pend[2]));
        exp_q.push_back(model_mem[2]);
        #1;
        exp_v = exp_q.pop_front(); n_tests++;
        if (DATA_W'(busy0_a) !== exp_v) begin n_fail++; $display("FAIL preclear_busy0: got %0h want %0h", busy0_a, exp_v); end
        exp_v = exp_q.pop_front(); n_tests++;
        if (q0_a !== exp_v) begin n_fail++; $display("FAIL preclear_q0: got %0h want %0h", q0_a, exp_v); end
        clr = 1'b1;
        tick();
        idle();
        r0 = 5'd2; r1 = 5'd2;
        sweep_checks("clear");
        idle();
        model_clear();
        readback_all("clear_rd");
    endtask

    task automatic test_reset_mid_sweep();
        idle();
        we0 = 1'b1; s0 = 5'd12; d0 = 32'h0BAD_0BAD;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r1 = 5'd12;
        sweep_checks("mid_rst");
        idle();
        model_clear();
        readback_all("mid_rst_rd");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_collision();
        test_scoreboard();
        test_clear();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
